// File: rtl/traceback_unit.sv
// Viterbi survivor-path traceback: stores per-step decisions in a 2*TB_LEN ring,
// traces back from the newest step and emits one TB_LEN-bit block oldest-first.
module traceback_unit #(
   parameter int TB_LEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid,
   input  logic [15:0] dec_in,
   output logic        dec_ready,
   output logic        bit_out,
   output logic        bit_valid,
   output logic        busy
);

   localparam int DEPTH = 2 * TB_LEN;
   localparam int AW    = $clog2(DEPTH);
   localparam int TW    = $clog2(DEPTH + 1);
   localparam int BW    = $clog2(TB_LEN + 1);
   localparam int OW    = $clog2(TB_LEN);

   localparam logic [TW-1:0] TOT_FULL = TW'(DEPTH);
   localparam logic [TW-1:0] TOT_HALF = TW'(TB_LEN);
   localparam logic [BW-1:0] BLK_FULL = BW'(TB_LEN);
   localparam logic [OW-1:0] OUT_LAST = OW'(TB_LEN - 1);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_TRACE  = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [15:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   w_wr_ptr_nxt;
   logic [TW-1:0]   r_total;
   logic [TW-1:0]   w_total_nxt;
   logic [BW-1:0]   r_blk;
   logic [BW-1:0]   w_blk_nxt;
   logic [AW-1:0]   r_addr;
   logic [3:0]      r_s;
   logic [15:0]     r_rd_data;
   logic [TW-1:0]   r_tcnt;
   logic [OW-1:0]   r_ocnt;
   logic [TB_LEN-1:0] r_lifo;
   logic            w_accept;
   logic            w_start;

   assign dec_ready = (r_state != S_TRACE) && (r_blk < BLK_FULL);
   assign w_accept  = dec_valid && dec_ready;
   assign bit_valid = (r_state == S_OUTPUT);
   assign bit_out   = bit_valid && r_lifo[0];
   assign busy      = (r_state == S_TRACE) || (r_state == S_OUTPUT);

   // The first TB_LEN writes after reset only prime the training window, so
   // blk_cnt starts counting once total_cnt has reached TB_LEN.
   assign w_wr_ptr_nxt = w_accept ? r_wr_ptr + 1'b1 : r_wr_ptr;
   assign w_total_nxt  = (w_accept && r_total != TOT_FULL) ? r_total + 1'b1 : r_total;
   assign w_blk_nxt    = (w_accept && r_total >= TOT_HALF) ? r_blk + 1'b1 : r_blk;
   assign w_start      = (r_state == S_FILL) && (w_state_nxt == S_TRACE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FILL:   if (w_total_nxt == TOT_FULL && w_blk_nxt == BLK_FULL) w_state_nxt = S_TRACE;
         S_TRACE:  if (r_tcnt == TOT_FULL) w_state_nxt = S_OUTPUT;
         S_OUTPUT: if (r_ocnt == OUT_LAST) w_state_nxt = S_FILL;
         default:  w_state_nxt = S_FILL;
      endcase
   end

   // NOTE: the decision memory is deliberately not reset; every trace reads
   // only entries written since the last reset, and a reset port would stop
   // the array mapping onto RAM.
   always_ff @(posedge clk) begin
      if (!rst && w_accept) r_mem[r_wr_ptr] <= dec_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FILL;
         r_wr_ptr  <= '0;
         r_total   <= '0;
         r_blk     <= '0;
         r_addr    <= '0;
         r_s       <= '0;
         r_rd_data <= '0;
         r_tcnt    <= '0;
         r_ocnt    <= '0;
         r_lifo    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_total  <= w_total_nxt;
         r_blk    <= w_start ? '0 : w_blk_nxt;
         case (r_state)
            S_FILL: begin
               if (w_start) begin
                  r_addr <= w_wr_ptr_nxt - 1'b1;
                  r_s    <= '0;
                  r_tcnt <= '0;
               end
            end
            S_TRACE: begin
               // Reads lead the trellis step by one cycle: step k uses the word
               // fetched in trace cycle k.
               r_tcnt <= r_tcnt + 1'b1;
               r_ocnt <= '0;
               if (r_tcnt != TOT_FULL) begin
                  r_rd_data <= r_mem[r_addr];
                  r_addr    <= r_addr - 1'b1;
               end
               if (r_tcnt != '0) begin
                  if (r_tcnt > TOT_HALF) r_lifo <= {r_lifo[TB_LEN-2:0], r_s[3]};
                  r_s <= {r_s[2:0], r_rd_data[r_s]};
               end
            end
            S_OUTPUT: begin
               r_ocnt <= r_ocnt + 1'b1;
               r_lifo <= {1'b0, r_lifo[TB_LEN-1:1]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: a transaction-level model (write history plus
// phase countdowns) predicts every cycle's outputs; directed scenarios add fixed checks.
module tb_traceback_unit;

   localparam int TB_LEN = 32;
   localparam int DEPTH  = 2 * TB_LEN;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid;
   logic [15:0] dec_in;
   logic        dec_ready;
   logic        bit_out;
   logic        bit_valid;
   logic        busy;

   traceback_unit #(.TB_LEN(TB_LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .dec_valid (dec_valid),
      .dec_in    (dec_in),
      .dec_ready (dec_ready),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: full history of accepted words, next trigger write count,
   // remaining trace cycles, remaining output cycles, pending output bits.
   logic [15:0] hist[$];
   logic        exp_bits[$];
   int          m_writes, m_next_trig, m_trace_left, m_out_left;
   logic        e_ready, e_valid, e_bit, e_busy;

   task automatic model_reset();
      hist.delete();
      exp_bits.delete();
      m_writes     = 0;
      m_next_trig  = DEPTH;
      m_trace_left = 0;
      m_out_left   = 0;
   endtask

   task automatic model_expect();
      e_ready = (m_trace_left == 0) && (m_writes < m_next_trig);
      e_valid = (m_trace_left == 0) && (m_out_left > 0);
      e_bit   = e_valid ? exp_bits[0] : 1'b0;
      e_busy  = (m_trace_left > 0) || (m_out_left > 0);
   endtask

   task automatic model_trace();
      int   n, s;
      logic b [DEPTH];
      logic [15:0] w;
      n = hist.size();
      s = 0;
      for (int k = 0; k < DEPTH; k++) begin
         w    = hist[n - 1 - k];
         b[k] = (s / 8) != 0;
         s    = ((s * 2) % 16) + int'(w[s]);
      end
      for (int k = DEPTH - 1; k >= TB_LEN; k--) exp_bits.push_back(b[k]);
   endtask

   task automatic model_edge(input logic v, input logic [15:0] d);
      model_expect();
      if (v && e_ready) begin
         hist.push_back(d);
         m_writes++;
      end
      if (m_trace_left > 0) begin
         m_trace_left--;
         if (m_trace_left == 0) m_out_left = TB_LEN;
      end else if (m_out_left > 0) begin
         void'(exp_bits.pop_front());
         m_out_left--;
      end else if (m_writes == m_next_trig) begin
         model_trace();
         m_trace_left = DEPTH + 1;
         m_next_trig += TB_LEN;
      end
   endtask

   task automatic step(input logic v, input logic [15:0] d);
      dec_valid = v;
      dec_in    = d;
      @(posedge clk);
      model_edge(v, d);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic v);
      rst       = 1'b1;
      dec_valid = v;
      dec_in    = 16'($urandom);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst       = 1'b0;
      dec_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      n_vec++;
      if ({dec_ready, bit_valid, bit_out, busy} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_outputs: rdy/vld/bit/busy=%b required 1000",
                  {dec_ready, bit_valid, bit_out, busy});
      end
   endtask

   task automatic test_const_block(input string name, input logic [15:0] word, input logic exp_val);
      int lo, bv;
      do_reset(1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         model_expect();
         n_vec++;
         if ({dec_ready, bit_valid, bit_out, busy} !== {e_ready, e_valid, e_bit, e_busy}) begin
            n_err++;
            $display("FAIL %s_fill cyc %0d: rdy/vld/bit/busy=%b required %b", name, i,
                     {dec_ready, bit_valid, bit_out, busy}, {e_ready, e_valid, e_bit, e_busy});
         end
         step(1'b1, word);
      end
      lo = 0;
      bv = 0;
      for (int c = 0; c < 110; c++) begin
         model_expect();
         n_vec++;
         if ({dec_ready, bit_valid, bit_out, busy} !== {e_ready, e_valid, e_bit, e_busy}) begin
            n_err++;
            $display("FAIL %s_model cyc %0d: rdy/vld/bit/busy=%b required %b", name, c,
                     {dec_ready, bit_valid, bit_out, busy}, {e_ready, e_valid, e_bit, e_busy});
         end
         if (!dec_ready) lo++;
         if (bit_valid) begin
            bv++;
            n_vec++;
            if (bit_out !== exp_val) begin
               n_err++;
               $display("FAIL %s_bit cyc %0d: bit_out=%b required %b", name, c, bit_out, exp_val);
            end
         end
         if (c < DEPTH + 1 + TB_LEN) begin
            n_vec++;
            if (busy !== 1'b1) begin
               n_err++;
               $display("FAIL %s_busy cyc %0d: busy=%b required 1", name, c, busy);
            end
         end
         step(1'b0, 16'h0000);
      end
      n_vec++;
      if (lo != DEPTH + 1) begin
         n_err++;
         $display("FAIL %s_ready_low: %0d cycles required %0d", name, lo, DEPTH + 1);
      end
      n_vec++;
      if (bv != TB_LEN) begin
         n_err++;
         $display("FAIL %s_bit_count: %0d bits required %0d", name, bv, TB_LEN);
      end
   endtask

   task automatic test_pattern();
      logic pat [DEPTH];
      int   j;
      do_reset(1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         pat[i] = 1'($urandom);
         step(1'b1, pat[i] ? 16'hFFFF : 16'h0000);
      end
      // Uniform decision words shift their bit straight into the state, so the
      // bit decoded at step k is the decision four steps newer.
      j = 0;
      for (int c = 0; c < 120; c++) begin
         if (bit_valid) begin
            n_vec++;
            if (j >= TB_LEN || bit_out !== pat[4 + j]) begin
               n_err++;
               $display("FAIL pattern_bit %0d: bit_out=%b required %b", j, bit_out,
                        (j < TB_LEN) ? pat[4 + j] : 1'bx);
            end
            j++;
         end
         step(1'b0, 16'h0000);
      end
      n_vec++;
      if (j != TB_LEN) begin
         n_err++;
         $display("FAIL pattern_count: %0d bits required %0d", j, TB_LEN);
      end
   endtask

   task automatic test_continuous();
      int bv;
      do_reset(1'b0);
      bv = 0;
      for (int c = 0; c < 300; c++) begin
         model_expect();
         n_vec++;
         if ({dec_ready, bit_valid, bit_out, busy} !== {e_ready, e_valid, e_bit, e_busy}) begin
            n_err++;
            $display("FAIL continuous cyc %0d: rdy/vld/bit/busy=%b required %b", c,
                     {dec_ready, bit_valid, bit_out, busy}, {e_ready, e_valid, e_bit, e_busy});
         end
         if (bit_valid) bv++;
         step(1'b1, 16'($urandom));
      end
      n_vec++;
      if (bv != 2 * TB_LEN) begin
         n_err++;
         $display("FAIL continuous_bit_count: %0d bits required %0d", bv, 2 * TB_LEN);
      end
   endtask

   task automatic test_reset_mid_output();
      int  bv;
      bit  hit;
      do_reset(1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 16'($urandom));
      bv  = 0;
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         if (bit_valid) bv++;
         if (bv == 10) hit = 1;
         else step(1'b0, 16'h0000);
      end
      n_vec++;
      if (!hit) begin
         n_err++;
         $display("FAIL midreset_reach: saw %0d output cycles required 10", bv);
      end
      do_reset(1'b0);
      n_vec++;
      if ({dec_ready, bit_valid, bit_out, busy} !== 4'b1000) begin
         n_err++;
         $display("FAIL midreset_after: rdy/vld/bit/busy=%b required 1000",
                  {dec_ready, bit_valid, bit_out, busy});
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_vec++;
         if ({dec_ready, bit_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL midreset_refill %0d: rdy/vld/busy=%b required 100", i,
                     {dec_ready, bit_valid, busy});
         end
         step(1'b1, 16'($urandom));
      end
      n_vec++;
      if ({dec_ready, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL midreset_trace_start: rdy/busy=%b required 01", {dec_ready, busy});
      end
      for (int c = 0; c < 100; c++) begin
         model_expect();
         n_vec++;
         if ({dec_ready, bit_valid, bit_out, busy} !== {e_ready, e_valid, e_bit, e_busy}) begin
            n_err++;
            $display("FAIL midreset_block cyc %0d: rdy/vld/bit/busy=%b required %b", c,
                     {dec_ready, bit_valid, bit_out, busy}, {e_ready, e_valid, e_bit, e_busy});
         end
         step(1'b0, 16'h0000);
      end
   endtask

   task automatic test_random();
      do_reset(1'b1);
      for (int c = 0; c < 600; c++) begin
         model_expect();
         n_vec++;
         if ({dec_ready, bit_valid, bit_out, busy} !== {e_ready, e_valid, e_bit, e_busy}) begin
            n_err++;
            $display("FAIL random cyc %0d: rdy/vld/bit/busy=%b required %b", c,
                     {dec_ready, bit_valid, bit_out, busy}, {e_ready, e_valid, e_bit, e_busy});
         end
         step(($urandom % 4) != 0, 16'($urandom));
      end
   endtask

   initial begin
      rst       = 1'b1;
      dec_valid = 1'b0;
      dec_in    = 16'h0000;
      model_reset();
      @(negedge clk);
      test_reset();
      test_const_block("zeros", 16'h0000, 1'b0);
      test_const_block("ones", 16'hFFFF, 1'b1);
      test_pattern();
      test_continuous();
      test_reset_mid_output();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
